// File: rtl/seven_segment_scan_controller_pkg.sv
// seven_segment_scan_controller_pkg: shared types, constants and helpers for the scan controller.
package seven_seg_pkg;
  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  function automatic logic digit_is_leading_zero(input logic [63:0] value, input int unsigned k);
    return k != 0 && (value >> (4 * k)) == '0;
  endfunction
endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// seven_segment_scan_controller_if: load handshake plus segment/digit pin bundle.
interface seven_segment_scan_controller_if #(parameter int NUM_DIGITS = 2);
  logic                    i_Load;
  logic [4*NUM_DIGITS-1:0] i_Value;
  logic                    i_Blank_Leading_Zeros;
  logic                    o_Ready;
  logic                    o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D;
  logic                    o_Segment_E, o_Segment_F, o_Segment_G;
  logic [NUM_DIGITS-1:0]   o_Digit_En;
  modport master (
    output i_Load, i_Value, i_Blank_Leading_Zeros,
    input  o_Ready, o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
           o_Segment_E, o_Segment_F, o_Segment_G, o_Digit_En
  );
  modport slave (
    input  i_Load, i_Value, i_Blank_Leading_Zeros,
    output o_Ready, o_Segment_A, o_Segment_B, o_Segment_C, o_Segment_D,
           o_Segment_E, o_Segment_F, o_Segment_G, o_Digit_En
  );
endinterface

// File: rtl/seven_segment_scan_controller_decoder.sv
// seven_segment_scan_controller_decoder: hex nibble to segments, bit6..0 = A..G, active-high.
module seven_segment_scan_controller_decoder (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    case (nibble_i)
      4'h0: seg_o = 7'h7E;
      4'h1: seg_o = 7'h30;
      4'h2: seg_o = 7'h6D;
      4'h3: seg_o = 7'h79;
      4'h4: seg_o = 7'h33;
      4'h5: seg_o = 7'h5B;
      4'h6: seg_o = 7'h5F;
      4'h7: seg_o = 7'h70;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h7B;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h1F;
      4'hC: seg_o = 7'h4E;
      4'hD: seg_o = 7'h3D;
      4'hE: seg_o = 7'h4F;
      4'hF: seg_o = 7'h47;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: time-multiplexes one hex decoder across NUM_DIGITS digits
// with a blank gap before each drive interval and tear-free frame updates.
module seven_segment_scan_controller
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250,
  parameter int ACTIVE_LOW     = 1
) (
  input logic i_Clk,
  input logic i_Rst,
  seven_segment_scan_controller_if.slave bus
);
  localparam int CW = $clog2((CLKS_PER_DIGIT > BLANK_CLKS ? CLKS_PER_DIGIT : BLANK_CLKS) + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS > 0 ? BLANK_CLKS - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam scan_state_t ST_RESET = BLANK_CLKS > 0 ? ST_BLANK : ST_DRIVE;
  localparam logic AL = ACTIVE_LOW != 0;
  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ {7{AL}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{AL}};
  scan_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d, shadow_q, shadow_d;
  logic [6:0] seg_q, seg_d, seg_raw;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic [3:0] nibble;
  logic last, wrap, accept, dark, on;
  always_comb begin
    last = state_q == ST_DRIVE ? cnt_q == DRIVE_LAST : cnt_q == BLANK_LAST;
    wrap = state_q == ST_DRIVE && last && idx_q == IDX_LAST;
    accept = bus.i_Load && !pend_q;
    state_d = last ? ((state_q == ST_DRIVE && BLANK_CLKS > 0) ? ST_BLANK : ST_DRIVE) : state_q;
    cnt_d = last ? '0 : cnt_q + 1'b1;
    idx_d = (state_q == ST_DRIVE && last) ? (idx_q == IDX_LAST ? '0 : idx_q + 1'b1) : idx_q;
    pend_d = accept || (pend_q && !wrap);
    pending_d = accept ? bus.i_Value : pending_q;
    shadow_d = (wrap && pend_q) ? pending_q : shadow_q;
  end
  // Outputs are registered from next-state values so pins move on the same edge as the FSM.
  assign nibble = shadow_d[{idx_d, 2'b00} +: 4];
  seven_segment_scan_controller_decoder u_dec (.nibble_i(nibble), .seg_o(seg_raw));
  always_comb begin
    dark = bus.i_Blank_Leading_Zeros && digit_is_leading_zero(64'(shadow_d), 32'(idx_d));
    on = state_d == ST_DRIVE && !dark;
    seg_d = (on ? seg_raw : SEG_BLANK) ^ {7{AL}};
    en_d = (on ? NUM_DIGITS'(1) << idx_d : '0) ^ EN_OFF;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      pending_q <= '0;
      shadow_q  <= '0;
      seg_q     <= SEG_OFF;
      en_q      <= EN_OFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
    end
  end
  assign bus.o_Ready = !pend_q;
  assign {bus.o_Segment_A, bus.o_Segment_B, bus.o_Segment_C, bus.o_Segment_D,
          bus.o_Segment_E, bus.o_Segment_F, bus.o_Segment_G} = seg_q;
  assign bus.o_Digit_En = en_q;
endmodule
